// File: rtl/avg_pool_ctrl_if.sv
// Sample-in / result-out stream bundle for avg_pool_ctrl.
// The master side is the environment and the slave side is the controller.
interface avg_pool_ctrl_if #(
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;

  // Both streams use valid/ready semantics. A beat transfers on a rising edge
  // where valid and ready are both 1. Once valid is raised, it and its data
  // stay stable until that transfer happens. Ready may change at any time.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/avg_pool_ctrl.sv
// Average-pooling job sequencer: clears the pool, feeds WINDOW samples per window, waits out the pool latency and emits one result per window.
// Optional macro AVG_POOL_CTRL_STALL_CNT_EN adds the stall_cnt output.
module avg_pool_ctrl #(
  parameter int DATA_W   = 32,
  parameter int WINDOW   = 4,
  parameter int PIPE_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              cfg_num_windows,
  avg_pool_ctrl_if.slave           bus,
  output logic                     pool_clr,
  output logic                     pool_en,
  output logic signed [DATA_W-1:0] pool_data,
  input  logic signed [DATA_W-1:0] pool_avg,
  output logic                     busy,
  output logic                     done,
`ifdef AVG_POOL_CTRL_STALL_CNT_EN
  output logic [15:0]              stall_cnt,
`endif
  output logic [2:0]               dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUTPUT, S_FIN
  } state_t;

  state_t      state;
  logic [15:0] num_win;
  logic [15:0] win_cnt;
  logic [7:0]  samp_cnt;
  logic [3:0]  lat_cnt;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      num_win       <= '0;
      win_cnt       <= '0;
      samp_cnt      <= '0;
      lat_cnt       <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      pool_clr      <= 1'b0;
      pool_en       <= 1'b0;
      pool_data     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      pool_clr <= 1'b0;
      pool_en  <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_win <= cfg_num_windows;
            win_cnt <= '0;
            busy    <= 1'b1;
            if (cfg_num_windows == 16'd0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state    <= S_CLEAR;
              pool_clr <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          samp_cnt     <= '0;
          bus.in_ready <= 1'b1;
          state        <= S_FEED;
        end
        S_FEED: begin
          if (bus.in_valid && bus.in_ready) begin
            pool_data <= bus.in_data;
            pool_en   <= 1'b1;
            samp_cnt  <= samp_cnt + 8'd1;
            if (samp_cnt == 8'(WINDOW - 1)) begin
              bus.in_ready <= 1'b0;
              lat_cnt      <= '0;
              state        <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The first DRAIN cycle is the one carrying the last pool_en,
          // so lat_cnt equals the number of cycles elapsed since it.
          if (lat_cnt == 4'(PIPE_LAT)) begin
            bus.out_data  <= pool_avg;
            bus.out_valid <= 1'b1;
            state         <= S_OUTPUT;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            win_cnt       <= win_cnt + 16'd1;
            if (win_cnt + 16'd1 == num_win) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else begin
              state    <= S_CLEAR;
              pool_clr <= 1'b1;
            end
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AVG_POOL_CTRL_STALL_CNT_EN
  // Only an accepted start clears the count; starts during a job are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if (busy && ((state == S_FEED && !bus.in_valid) ||
                          (state == S_OUTPUT && !bus.out_ready)) &&
                 stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/avg_pool_ctrl.md
AVG_POOL_CTRL -- requirements
Module: avg_pool_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the signed sample and result width.
REQ-002 The block SHALL have parameter WINDOW, default 4, the samples per pooling window (range 2..255).
REQ-003 The block SHALL have parameter PIPE_LAT, default 4, the cycles from the last pool_en to a valid pool_avg (range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port start, input, 1 bit: a one-cycle job start request.
REQ-007 The block SHALL have port cfg_num_windows, input, 16 bits: windows per job, sampled at accepted start.
REQ-008 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_W signed): the sample stream.
REQ-009 The block SHALL have ports pool_clr, pool_en and pool_data: outputs of 1, 1 and DATA_W bits driving the pooling datapath.
REQ-010 The block SHALL have port pool_avg, input, DATA_W signed: the pooling datapath result.
REQ-011 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, DATA_W signed): the result stream.
REQ-012 The block SHALL have ports busy and done, outputs of 1 bit each: job active, and a one-cycle job-complete pulse.

Function
REQ-013 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN, OUTPUT and FIN.
REQ-014 IDLE: start=1 SHALL latch cfg_num_windows and zero the window count; the next state is CLEAR, or FIN if the value is 0.
REQ-015 CLEAR SHALL last one cycle with pool_clr=1, zero the sample count, then enter FEED.
REQ-016 In FEED, in_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-017 Each FEED handshake (in_valid&in_ready) SHALL register in_data to pool_data and set pool_en=1 for exactly the following cycle.
REQ-018 pool_en SHALL be 0 in every other cycle, and pool_data SHALL hold its last value.
REQ-019 The handshake accepting sample WINDOW of a window SHALL move the FSM to DRAIN.
REQ-020 DRAIN SHALL capture pool_avg into out_data exactly PIPE_LAT cycles after the cycle in which the last pool_en was high, then enter OUTPUT.
REQ-021 OUTPUT SHALL hold out_valid=1 and a stable out_data until out_ready=1.
REQ-022 On the out handshake, the window count SHALL increment; the next state is FIN if it reaches the latched count, else CLEAR.
REQ-023 FIN SHALL pulse done=1 for one cycle and return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-026 The sample and window counters SHALL NOT wrap within a job; their widths SHALL be 8 bits and 16 bits respectively.
REQ-027 in_valid=0 in FEED SHALL stall the window without timeout.
REQ-028 out_ready=1 arriving in the same cycle that out_valid rises SHALL complete the handshake in that cycle.

Reset
REQ-029 rst=1 SHALL force the FSM to IDLE and clear all counters, including mid-job, and the job SHALL be discarded.
REQ-030 Reset values SHALL be: in_ready=0, pool_clr=0, pool_en=0, pool_data=0, out_valid=0, out_data=0, busy=0, done=0.
REQ-031 rst SHALL take priority over start in the same cycle.

Configuration
REQ-032 With macro AVG_POOL_CTRL_STALL_CNT_EN defined, output stall_cnt[15:0] SHALL count the cycles with busy=1 and either (FEED and in_valid=0) or (OUTPUT and out_ready=0).
REQ-033 stall_cnt SHALL saturate at 16'hFFFF, clear on accepted start and clear on rst.
REQ-034 Without AVG_POOL_CTRL_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-035 start, cfg_num_windows=1, samples 4,8,12,16 back-to-back, behavioural pool model (sum>>2, PIPE_LAT=4) -> one pool_clr, four pool_en pulses, out_data=10, done pulse.
REQ-036 cfg_num_windows=0 -> busy high for exactly one cycle (FIN) with done=1, no pool_clr and no pool_en.
REQ-037 cfg_num_windows=3 with out_ready held 0 for 5 cycles per result -> out_data held stable, three results in order, pool_clr before each window.
REQ-038 rst asserted during DRAIN of window 2 -> next cycle all outputs at reset values; a fresh job then completes normally.
REQ-039 start pulsed while busy, and in_valid gaps of 3 cycles between samples -> start ignored, result unchanged, stall_cnt=9 per window when AVG_POOL_CTRL_STALL_CNT_EN is defined.
